// File: rtl/score_counter.sv
// Four-digit BCD up-counter with carry pulses and saturation at 9999; latency 1 cycle from inc to digits.
// No backpressure: one inc per clock is accepted unless held, cleared or saturated (extra incs at 9999 only pulse sat).
module score_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        hold,
    input  logic        inc,
    output logic [15:0] digits,
    output logic [2:0]  carry,
    output logic        full,
    output logic        sat
);

    logic [3:0][3:0] cur;
    logic [3:0][3:0] nxt;
    logic [3:0]      wrap;
    logic            nxt_full;

    assign cur = digits;

    // A digit wraps only when it and every lower digit sit at 9, so the whole
    // ripple resolves in one cycle and 0999 -> 1000 lands on a single edge.
    always_comb begin
        wrap = '0;
        nxt  = cur;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                wrap[k] = (cur[k] == 4'd9);
                nxt[k]  = wrap[k] ? 4'd0 : cur[k] + 4'd1;
            end else if (wrap[k-1]) begin
                wrap[k] = (cur[k] == 4'd9);
                nxt[k]  = wrap[k] ? 4'd0 : cur[k] + 4'd1;
            end
        end
    end

    assign nxt_full = (nxt == 16'h9999);

    always_ff @(posedge clk) begin
        if (!rst) begin
            digits <= 16'h0000;
            carry  <= 3'b000;
            full   <= 1'b0;
            sat    <= 1'b0;
        end else if (clear) begin
            digits <= 16'h0000;
            carry  <= 3'b000;
            full   <= 1'b0;
            sat    <= 1'b0;
        end else if (hold || !inc) begin
            carry  <= 3'b000;
            sat    <= 1'b0;
        end else if (full) begin
            // Saturated: the count never wraps back to 0000.
            carry  <= 3'b000;
            sat    <= 1'b1;
        end else begin
            digits <= nxt;
            carry  <= wrap[2:0];
            full   <= nxt_full;
            sat    <= 1'b0;
        end
    end

endmodule
